// File: rtl/hw_accel_dma_stream_driver_if.sv
// hw_accel_dma_stream_driver_if
// Purpose: groups the two DMA streams between the stream driver and the
//          accelerator wrapper (MM2S read stream and S2MM write stream).
// Signals:
//   dma_rready  read-stream ready, driven by the wrapper
//   dma_rvalid  read-stream valid, driven by the stream driver
//   dma_rkeep   read-stream byte keep, driven by the stream driver
//   dma_rdata   read-stream data, driven by the stream driver
//   dma_wvalid  write-stream valid, driven by the wrapper
//   dma_wlast   write-stream last, driven by the wrapper
//   dma_wdata   write-stream data, driven by the wrapper
//   dma_wready  write-stream ready, driven by the stream driver
// Modports: master = stream driver (DMA channel role), slave = wrapper.
interface hw_accel_dma_stream_driver_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    dma_rready;
  logic                    dma_rvalid;
  logic [DATA_WIDTH/8-1:0] dma_rkeep;
  logic [DATA_WIDTH-1:0]   dma_rdata;
  logic                    dma_wvalid;
  logic                    dma_wlast;
  logic [DATA_WIDTH-1:0]   dma_wdata;
  logic                    dma_wready;

  modport master (
    input  dma_rready,
    output dma_rvalid,
    output dma_rkeep,
    output dma_rdata,
    input  dma_wvalid,
    input  dma_wlast,
    input  dma_wdata,
    output dma_wready
  );

  modport slave (
    output dma_rready,
    input  dma_rvalid,
    input  dma_rkeep,
    input  dma_rdata,
    output dma_wvalid,
    output dma_wlast,
    output dma_wdata,
    input  dma_wready
  );
endinterface

// File: rtl/hw_accel_dma_stream_driver.sv
// hw_accel_dma_stream_driver
// Purpose: stands in for the DMA controller during bring-up/loopback.
//   The read side sources one frame of pattern words (seed + index) into the
//   wrapper; the write side sinks the processed stream with programmable
//   wready throttling, checks wlast framing, counts beats and sums a checksum.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start          one-cycle pulse, begins one frame when idle
//   pattern_seed   base value of the generated pattern
//   stall_mask     wready throttle, bit k stalls wready in phase k
//   busy, done     frame in progress / one-cycle end-of-frame pulse
//   err_wlast      sticky wlast framing error
//   err_timeout    sticky write-stream idle timeout
//   rx_word_count  write beats accepted this frame
//   checksum       mod-2^32 sum of accepted dma_wdata[31:0]
//   dma            stream interface (master modport)
module hw_accel_dma_stream_driver #(
  parameter int DATA_WIDTH      = 32,
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int TRANSFER_LENGTH = 1920,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pattern_seed,
  input  logic [7:0]  stall_mask,
  output logic        busy,
  output logic        done,
  output logic        err_wlast,
  output logic        err_timeout,
  output logic [31:0] rx_word_count,
  output logic [31:0] checksum,
  hw_accel_dma_stream_driver_if.master dma
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [31:0] FRAME_BEATS   = 32'(FRAME_WIDTH * FRAME_HEIGHT);
  localparam logic [31:0] LAST_TX       = FRAME_BEATS - 32'd1;
  localparam logic [31:0] LAST_BURST    = 32'(TRANSFER_LENGTH - 1);
  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

  logic [1:0]  state;
  logic [2:0]  phase;
  logic [31:0] seed_q;
  logic [31:0] tx_index;
  logic [31:0] burst_cnt;
  logic [31:0] idle_cnt;

  logic rd_beat;
  logic wr_beat;
  logic wlast_bad;
  logic timeout_hit;

  assign busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  // The seed is captured at start so the presented word cannot move while
  // the wrapper holds off rready, even if the register block rewrites it.
  assign dma.dma_rvalid = (state == ST_RUN);
  assign dma.dma_rkeep  = dma.dma_rvalid ? '1 : '0;
  assign dma.dma_rdata  = dma.dma_rvalid ? DATA_WIDTH'(seed_q + tx_index) : '0;

  // busy already excludes DONE, so no separate DONE term is needed here.
  assign dma.dma_wready = busy && !stall_mask[phase];

  assign rd_beat = dma.dma_rvalid && dma.dma_rready;
  assign wr_beat = dma.dma_wvalid && dma.dma_wready;

  // A beat past the frame size is a framing error regardless of wlast.
  assign wlast_bad = (dma.dma_wlast != (burst_cnt == LAST_BURST)) ||
                     (rx_word_count >= FRAME_BEATS);

  // The idle counter runs from the last write beat even while still in RUN,
  // so the timeout measures the real gap since the final accepted beat.
  assign timeout_hit = !wr_beat && (idle_cnt >= TIMEOUT_LIMIT - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      phase         <= '0;
      seed_q        <= '0;
      tx_index      <= '0;
      burst_cnt     <= '0;
      idle_cnt      <= '0;
      rx_word_count <= '0;
      checksum      <= '0;
      err_wlast     <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_RUN;
            seed_q        <= pattern_seed;
            phase         <= '0;
            tx_index      <= '0;
            burst_cnt     <= '0;
            idle_cnt      <= '0;
            rx_word_count <= '0;
            checksum      <= '0;
            err_wlast     <= 1'b0;
            err_timeout   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (rd_beat) begin
            tx_index <= tx_index + 32'd1;
            if (tx_index == LAST_TX) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Completion is tested first so it wins over a coincident timeout.
          if (rx_word_count >= FRAME_BEATS) begin
            state <= ST_DONE;
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (busy) begin
        phase <= phase + 3'd1;
        if (wr_beat) begin
          idle_cnt <= '0;
        end else if (idle_cnt < TIMEOUT_LIMIT) begin
          idle_cnt <= idle_cnt + 32'd1;
        end
      end

      if (wr_beat) begin
        rx_word_count <= rx_word_count + 32'd1;
        checksum      <= checksum + dma.dma_wdata[31:0];
        burst_cnt     <= (burst_cnt == LAST_BURST) ? 32'd0 : burst_cnt + 32'd1;
        if (wlast_bad) begin
          err_wlast <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hw_accel_dma_stream_driver.sv
// tb_hw_accel_dma_stream_driver
// Purpose: scoreboard bench for hw_accel_dma_stream_driver with a small
//   frame (4x2 = 8 beats, bursts of 4, timeout 16). Stimulus pushes expected
//   read words and per-frame results into queues; a monitor process pops and
//   compares whenever the DUT presents a read beat or a done pulse, and also
//   checks wready against an independent phase/stall model every cycle.
module tb_hw_accel_dma_stream_driver;

  localparam int DW = 32;
  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pattern_seed = '0;
  logic [7:0]  stall_mask = '0;
  logic        busy;
  logic        done;
  logic        err_wlast;
  logic        err_timeout;
  logic [31:0] rx_word_count;
  logic [31:0] checksum;

  hw_accel_dma_stream_driver_if #(.DATA_WIDTH(DW)) dma ();

  hw_accel_dma_stream_driver #(
    .DATA_WIDTH     (DW),
    .FRAME_WIDTH    (4),
    .FRAME_HEIGHT   (2),
    .TRANSFER_LENGTH(4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pattern_seed (pattern_seed),
    .stall_mask   (stall_mask),
    .busy         (busy),
    .done         (done),
    .err_wlast    (err_wlast),
    .err_timeout  (err_timeout),
    .rx_word_count(rx_word_count),
    .checksum     (checksum),
    .dma          (dma)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] seed;
    logic [7:0]  stall;
    bit          rtog;
    logic [7:0]  wlast_mask;
    int          wr_beats;
    int          xstart;
    logic [31:0] exp_cnt;
    logic [31:0] exp_cs;
    bit          exp_ew;
    bit          exp_et;
    int          exp_delay;
  } vec_t;

  typedef struct {
    logic [31:0] cnt;
    logic [31:0] cs;
    bit          ew;
    bit          et;
    int          delay;
  } frame_t;

  logic [31:0] exp_rdata[$];
  frame_t      exp_frame[$];
  int          errors = 0;
  int          checks = 0;
  vec_t        vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one frame: loopback writes follow the read beats seen so far.
  task automatic applyStimulus(input vec_t v);
    int     rd_n = 0;
    int     wr_n = 0;
    int     cyc = 0;
    bit     rd_b;
    bit     wr_b;
    bit     seen_done = 1'b0;
    frame_t f;
    for (int i = 0; i < NB; i++) exp_rdata.push_back(v.seed + 32'(i));
    f.cnt = v.exp_cnt;
    f.cs = v.exp_cs;
    f.ew = v.exp_ew;
    f.et = v.exp_et;
    f.delay = v.exp_delay;
    exp_frame.push_back(f);
    @(posedge clk); #1;
    pattern_seed = v.seed;
    stall_mask = v.stall;
    start = 1'b1;
    dma.dma_rready = 1'b1;
    while (!seen_done && cyc < 300) begin
      @(negedge clk);
      rd_b = dma.dma_rvalid && dma.dma_rready;
      wr_b = dma.dma_wvalid && dma.dma_wready;
      seen_done = done;
      @(posedge clk); #1;
      cyc++;
      start = (cyc == v.xstart);
      if (rd_b) rd_n++;
      if (wr_b) wr_n++;
      dma.dma_rready = v.rtog ? (cyc % 2 == 0) : 1'b1;
      dma.dma_wvalid = (wr_n < rd_n) && (wr_n < v.wr_beats);
      dma.dma_wdata = v.seed + 32'(wr_n);
      dma.dma_wlast = (wr_n < NB) ? v.wlast_mask[wr_n] : 1'b0;
    end
    if (!seen_done) checkOutput("frame_timeout", 32'd0, 32'd1);
    start = 1'b0;
    dma.dma_rready = 1'b0;
    dma.dma_wvalid = 1'b0;
    dma.dma_wlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err_wlast"}, 32'(err_wlast), 32'd0);
    checkOutput({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
    checkOutput({tag, "_rx_word_count"}, rx_word_count, 32'd0);
    checkOutput({tag, "_checksum"}, checksum, 32'd0);
    checkOutput({tag, "_rvalid"}, 32'(dma.dma_rvalid), 32'd0);
    checkOutput({tag, "_rkeep"}, 32'(dma.dma_rkeep), 32'd0);
    checkOutput({tag, "_rdata"}, dma.dma_rdata, 32'd0);
    checkOutput({tag, "_wready"}, 32'(dma.dma_wready), 32'd0);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    int     ph = 0;
    int     cyc = 0;
    int     last_wr = -1;
    int     to_delay = 0;
    bit     prev_et = 1'b0;
    bit     exp_w;
    frame_t f;
    forever begin
      @(negedge clk);
      cyc++;
      if (dma.dma_rvalid) begin
        if (exp_rdata.size() == 0) begin
          checkOutput("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          checkOutput("rdata", dma.dma_rdata, exp_rdata[0]);
          checkOutput("rkeep", 32'(dma.dma_rkeep), 32'hF);
          if (dma.dma_rready) void'(exp_rdata.pop_front());
        end
      end else begin
        checkOutput("rkeep_idle", 32'(dma.dma_rkeep), 32'd0);
      end
      exp_w = busy ? !stall_mask[ph] : 1'b0;
      checkOutput("wready", 32'(dma.dma_wready), 32'(exp_w));
      ph = busy ? (ph + 1) % 8 : 0;
      if (err_timeout && !prev_et) to_delay = (cyc - 1) - last_wr;
      prev_et = err_timeout;
      if (dma.dma_wvalid && dma.dma_wready) last_wr = cyc;
      if (done) begin
        if (exp_frame.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          f = exp_frame.pop_front();
          checkOutput("rx_word_count", rx_word_count, f.cnt);
          checkOutput("checksum", checksum, f.cs);
          checkOutput("err_wlast", 32'(err_wlast), 32'(f.ew));
          checkOutput("err_timeout", 32'(err_timeout), 32'(f.et));
          checkOutput("busy_at_done", 32'(busy), 32'd0);
          checkOutput("read_beats_left", 32'(exp_rdata.size()), 32'd0);
          if (f.delay > 0) checkOutput("timeout_delay", 32'(to_delay), 32'(f.delay));
        end
      end
    end
  end

  initial begin
    dma.dma_rready = 1'b0;
    dma.dma_wvalid = 1'b0;
    dma.dma_wlast = 1'b0;
    dma.dma_wdata = '0;

    // seed, stall, rtog, wlast_mask, wr_beats, xstart, cnt, cs, ew, et, delay
    vecs[0] = '{seed:32'h10, stall:8'h00, rtog:1'b0, wlast_mask:8'h88, wr_beats:8, xstart:-1,
                exp_cnt:32'd8, exp_cs:32'h9C, exp_ew:1'b0, exp_et:1'b0, exp_delay:0};
    vecs[1] = '{seed:32'h10, stall:8'h00, rtog:1'b1, wlast_mask:8'h88, wr_beats:8, xstart:-1,
                exp_cnt:32'd8, exp_cs:32'h9C, exp_ew:1'b0, exp_et:1'b0, exp_delay:0};
    vecs[2] = '{seed:32'h10, stall:8'h05, rtog:1'b0, wlast_mask:8'h88, wr_beats:8, xstart:-1,
                exp_cnt:32'd8, exp_cs:32'h9C, exp_ew:1'b0, exp_et:1'b0, exp_delay:0};
    vecs[3] = '{seed:32'h10, stall:8'h00, rtog:1'b0, wlast_mask:8'h84, wr_beats:8, xstart:-1,
                exp_cnt:32'd8, exp_cs:32'h9C, exp_ew:1'b1, exp_et:1'b0, exp_delay:0};
    vecs[4] = '{seed:32'h10, stall:8'h00, rtog:1'b0, wlast_mask:8'h88, wr_beats:5, xstart:-1,
                exp_cnt:32'd5, exp_cs:32'h5A, exp_ew:1'b0, exp_et:1'b1, exp_delay:16};
    vecs[5] = '{seed:32'h100, stall:8'h00, rtog:1'b0, wlast_mask:8'h88, wr_beats:8, xstart:3,
                exp_cnt:32'd8, exp_cs:32'h81C, exp_ew:1'b0, exp_et:1'b0, exp_delay:0};

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      $display("[TB] scenario %0d", i + 1);
      applyStimulus(vecs[i]);
    end

    // Reset in the middle of RUN: no done pulse may follow.
    $display("[TB] scenario 6: reset mid-frame");
    for (int i = 0; i < NB; i++) exp_rdata.push_back(32'h40 + 32'(i));
    @(posedge clk); #1;
    pattern_seed = 32'h40;
    stall_mask = 8'h00;
    start = 1'b1;
    dma.dma_rready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_rdata.delete();
    #2;
    checkAllZero("midreset");
    dma.dma_rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle_after_reset_busy", 32'(busy), 32'd0);

    // New frame from IDLE with a second start pulse while busy.
    applyStimulus(vecs[5]);

    checkOutput("pending_frames", 32'(exp_frame.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hw_accel_dma_stream_driver.md
Name: hw_accel_dma_stream_driver

Overview:
- Stream-side counterpart of the accelerator wrapper's DMA ports. Plays the DMA channel role for bring-up and loopback without DDR.
- MM2S side: sources one frame of pattern words on the read stream into the wrapper.
- S2MM side: sinks the processed stream with programmable wready throttling, checks wlast framing, counts beats and accumulates a checksum.
- Sits in the test/bring-up top in place of the DMA controller, driven by a start pulse from the CPU's register block.

Parameters:
DATA_WIDTH, 32, stream data width (>=32)
FRAME_WIDTH, 640, pixels per line
FRAME_HEIGHT, 480, lines per frame
TRANSFER_LENGTH, 1920, beats per write transfer; wlast expected on the last beat of each
TIMEOUT_CYCLES, 65535, max idle cycles between write beats in DRAIN before abort

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begin one frame
pattern_seed  in  32  base value of generated pixel pattern
stall_mask  in  8  wready throttle; bit k=1 stalls wready in phase k
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at frame end
err_wlast  out  1  sticky: wlast missing or misplaced
err_timeout  out  1  sticky: DRAIN timeout expired
rx_word_count  out  32  write beats accepted this frame
checksum  out  32  mod-2^32 sum of dma_wdata[31:0] over accepted beats
dma_rready  in  1  read-stream ready from wrapper
dma_rvalid  out  1  read-stream valid
dma_rkeep  out  DATA_WIDTH/8  byte keep, all ones when valid
dma_rdata  out  DATA_WIDTH  read-stream data
dma_wvalid  in  1  write-stream valid
dma_wlast  in  1  write-stream last
dma_wdata  in  DATA_WIDTH  write-stream data
dma_wready  out  1  write-stream ready

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- Reset mid-frame aborts immediately; no done pulse is produced.
- Let N = FRAME_WIDTH*FRAME_HEIGHT.
- FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 clears rx_word_count, checksum, err_wlast, err_timeout, tx index and burst counter; next state RUN; busy=1 from the next cycle.
  - start while busy is ignored.
- RUN (source side):
  - dma_rvalid=1 and dma_rdata = zero-extended (pattern_seed + tx_index), 32-bit wrap.
  - Beat transfers when dma_rvalid & dma_rready. tx_index then increments, and data updates the next cycle.
  - Data and rvalid are held stable while rready=0.
  - After beat N-1 transfers, rvalid drops the next cycle and the FSM enters DRAIN.
  - dma_rkeep is all ones whenever rvalid=1, else 0.
- Sink side, RUN and DRAIN:
  - 3-bit phase counter increments every cycle while busy; resets to 0 on start.
  - dma_wready = busy & ~stall_mask[phase] & (state != DONE). It is combinational from registered state and phase.
  - Write beat = dma_wvalid & dma_wready. On a beat: rx_word_count += 1; checksum += dma_wdata[31:0].
  - Burst counter wraps at TRANSFER_LENGTH-1 -> 0.
  - err_wlast sets if dma_wlast != (burst_cnt == TRANSFER_LENGTH-1) on a beat.
  - Beats beyond N in the same frame are still accepted and counted, and also set err_wlast.
  - dma_wready is low in IDLE. Beats offered in IDLE are not accepted.
- DRAIN:
  - Idle counter resets on every write beat and increments otherwise.
  - rx_word_count reaching N goes to DONE.
  - Idle counter reaching TIMEOUT_CYCLES sets err_timeout and goes to DONE.
  - If both occur in the same cycle, completion wins and err_timeout stays 0.
- DONE: done=1 for exactly one cycle; busy=0 the same cycle; next state IDLE. Counters and errors are held until the next start.
- Write beats are also counted while still in RUN, since the accelerator output overlaps its input.
- Simultaneous read and write beats in the same cycle are both processed.

Test Plan:
Use FRAME_WIDTH=4, FRAME_HEIGHT=2 (N=8), TRANSFER_LENGTH=4, TIMEOUT_CYCLES=16.
1. Loopback rdata->wdata with rready=1, wvalid following, correct wlast on beats 3 and 7, seed=0x10, stall_mask=0 -> rdata 0x10..0x17; rx_word_count=8; checksum=0x9C; done pulses once; no errors.
2. Same as scenario 1 with rready toggling 1/0 every cycle -> rdata stable while rready=0; same checksum 0x9C.
3. stall_mask=8'b0000_0101 -> dma_wready low in phases 0 and 2; all 8 beats accepted; no errors.
4. wlast asserted on beat 2 instead of beat 3 -> err_wlast=1 and stays set after done.
5. Write stream stops after 5 beats -> err_timeout=1 sixteen cycles after the last beat; done pulses; rx_word_count=5.
6. Reset asserted mid-RUN, then start pulses while busy -> all outputs 0 after reset; no done pulse; a start while busy is ignored, a start from IDLE begins a new frame from seed.
